// File: rtl/multi_edge_pkg.sv
// Shared definitions for the multi-channel edge detector: the per-channel
// mode encoding and the helper that qualifies raw edges against it.
package multi_edge_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  function automatic logic qualify(input mode_t mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, glitch filter, accepted level, edge
// pulses, mode-qualified pulse, sticky flag and saturating edge counter.
module edge_chan
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  mode_t                mode,
  input  logic                 clr,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic                 edge_pulse,
  output logic                 sticky,
  output logic [CNT_WIDTH-1:0] edge_cnt
);

  localparam int                    FCNT_W    = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCNT_W-1:0]      fcnt;
  logic                   s;
  logic                   accept;
  logic                   rise_d;
  logic                   fall_d;
  logic                   qual_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A level change is accepted on the clock where the disagreement has
  // persisted for FILTER_CYCLES consecutive samples.
  always_comb begin
    accept = (s != level) && (fcnt == FCNT_LAST);
    rise_d = accept & s;
    fall_d = accept & ~s;
    qual_d = qualify(mode, rise_d, fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      fcnt <= '0;
    end else if (accept) begin
      level <= s;
      fcnt  <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      edge_pulse <= qual_d;
    end
  end

  // A qualified edge wins over a simultaneous clear in both sticky and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      if (qual_d) begin
        sticky <= 1'b1;
      end else if (clr) begin
        sticky <= 1'b0;
      end
      if (clr) begin
        edge_cnt <= qual_d ? CNT_WIDTH'(1) : '0;
      end else if (qual_d && (edge_cnt != CNT_MAX)) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: CHANNELS independent edge_chan instances with
// the mode and edge_cnt buses sliced per channel.
module multi_edge_detector
  import multi_edge_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           din,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clr,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS-1:0]           rise_pulse,
  output logic [CHANNELS-1:0]           fall_pulse,
  output logic [CHANNELS-1:0]           edge_pulse,
  output logic [CHANNELS-1:0]           sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_cnt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (din[i]),
      .mode       (mode_t'(mode[2*i +: 2])),
      .clr        (clr[i]),
      .level      (level[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .edge_pulse (edge_pulse[i]),
      .sticky     (sticky[i]),
      .edge_cnt   (edge_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic, all
// compared every cycle against a window-based reference model.
module tb_multi_edge_detector;
  import multi_edge_pkg::*;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int FC   = 3;
  localparam int CW   = 8;
  localparam int CW_S = 3;
  localparam int HIST = SS + FC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]      din, clr;
  logic [2*CH-1:0]    mode;
  logic [CH-1:0]      level, rise_pulse, fall_pulse, edge_pulse, sticky;
  logic [CH*CW-1:0]   edge_cnt;
  logic [CH-1:0]      level_s, rise_pulse_s, fall_pulse_s, edge_pulse_s, sticky_s;
  logic [CH*CW_S-1:0] edge_cnt_s;

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_pulse(edge_pulse), .sticky(sticky), .edge_cnt(edge_cnt)
  );

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .level(level_s), .rise_pulse(rise_pulse_s), .fall_pulse(fall_pulse_s),
    .edge_pulse(edge_pulse_s), .sticky(sticky_s), .edge_cnt(edge_cnt_s)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [CH-1:0] din_hist[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_edge, m_sticky;
  int            m_cnt[CH];
  int            m_cnt_s[CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    din_hist.delete();
    for (int k = 0; k < HIST; k++) din_hist.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_edge = '0; m_sticky = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c]   = 0;
      m_cnt_s[c] = 0;
    end
  endtask

  // Oldest FC samples in the history are what the filter sees this clock;
  // a level flips once all of them disagree with it.
  task automatic model_step();
    logic [CH-1:0] dropped;
    logic          acc;
    logic          qual;
    din_hist.push_back(din);
    dropped = din_hist.pop_front();
    m_rise = '0; m_fall = '0; m_edge = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 1'b1;
      for (int k = 0; k < FC; k++) if (din_hist[k][c] == m_level[c]) acc = 1'b0;
      if (acc) begin
        if (m_level[c]) m_fall[c] = 1'b1;
        else            m_rise[c] = 1'b1;
        m_level[c] = ~m_level[c];
      end
      qual = (m_rise[c] & mode[2*c]) | (m_fall[c] & mode[2*c+1]);
      m_edge[c] = qual;
      if (qual) m_sticky[c] = 1'b1;
      else if (clr[c]) m_sticky[c] = 1'b0;
      if (clr[c]) begin
        m_cnt[c]   = qual ? 1 : 0;
        m_cnt_s[c] = qual ? 1 : 0;
      end else if (qual) begin
        if (m_cnt[c]   < (1 << CW)   - 1) m_cnt[c]++;
        if (m_cnt_s[c] < (1 << CW_S) - 1) m_cnt_s[c]++;
      end
    end
  endtask

  task automatic check_outputs();
    check("level",  32'(level),      32'(m_level));
    check("rise",   32'(rise_pulse), 32'(m_rise));
    check("fall",   32'(fall_pulse), 32'(m_fall));
    check("edge",   32'(edge_pulse), 32'(m_edge));
    check("sticky", 32'(sticky),     32'(m_sticky));
    check("rise_fall_excl", 32'(rise_pulse & fall_pulse), 32'(0));
    check("level_s",  32'(level_s),      32'(m_level));
    check("edge_s",   32'(edge_pulse_s), 32'(m_edge));
    check("sticky_s", 32'(sticky_s),     32'(m_sticky));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("cnt%0d", c),   32'(edge_cnt[c*CW +: CW]),       32'(m_cnt[c]));
      check($sformatf("cnt_s%0d", c), 32'(edge_cnt_s[c*CW_S +: CW_S]), 32'(m_cnt_s[c]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // A sub-cycle pulse between two sampling edges.
  task automatic sliver_tick(input int ch);
    @(posedge clk);
    model_step();
    #1 din[ch] = 1'b1;
    #3 din[ch] = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic measure(input int ch, input bit want_rise, output int lat, output int width);
    lat = -1;
    width = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (want_rise ? rise_pulse[ch] : fall_pulse[ch]) begin
        if (lat < 0) lat = k;
        width++;
      end
    end
  endtask

  task automatic strobe_clr(input logic [CH-1:0] v);
    clr = v;
    tick();
    clr = '0;
  endtask

  // ---------------- stimulus ----------------
  int lat, width, n_rise, n_fall, n_edge;

  initial begin
    rst = 1'b1; din = '0; mode = '0; clr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    ticks(2);

    // Basic latency, all channels in MODE_BOTH
    mode = {CH{MODE_BOTH}};
    din[0] = 1'b1;
    measure(0, 1'b1, lat, width);
    check("rise_latency", 32'(lat), 32'(SS + FC));
    check("rise_width", 32'(width), 32'(1));
    check("basic_level", 32'(level[0]), 32'(1));
    check("basic_sticky", 32'(sticky[0]), 32'(1));
    check("basic_cnt1", 32'(edge_cnt[0 +: CW]), 32'(1));
    din[0] = 1'b0;
    measure(0, 1'b0, lat, width);
    check("fall_latency", 32'(lat), 32'(SS + FC));
    check("basic_cnt2", 32'(edge_cnt[0 +: CW]), 32'(2));

    // Glitch rejection on channel 1
    n_rise = 0;
    din[1] = 1'b1; ticks(2); din[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(); n_rise += int'(rise_pulse[1] | fall_pulse[1]); end
    for (int k = 0; k < 3; k++) sliver_tick(1);
    for (int k = 0; k < 8; k++) begin tick(); n_rise += int'(rise_pulse[1] | fall_pulse[1]); end
    check("glitch_pulses", 32'(n_rise), 32'(0));
    check("glitch_level", 32'(level[1]), 32'(0));
    n_rise = 0; n_fall = 0;
    din[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == FC) din[1] = 1'b0;
      tick();
      n_rise += int'(rise_pulse[1]);
      n_fall += int'(fall_pulse[1]);
    end
    check("min_pulse_rise", 32'(n_rise), 32'(1));
    check("min_pulse_fall", 32'(n_fall), 32'(1));

    // Mode qualification on channel 2
    mode[5:4] = MODE_FALL;
    strobe_clr(4'b0100);
    n_rise = 0; n_fall = 0; n_edge = 0;
    din[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin tick(); n_rise += int'(rise_pulse[2]); n_edge += int'(edge_pulse[2]); end
    check("fallmode_edge_on_rise", 32'(n_edge), 32'(0));
    din[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(); n_fall += int'(fall_pulse[2]); n_edge += int'(edge_pulse[2]); end
    check("fallmode_rise_seen", 32'(n_rise), 32'(1));
    check("fallmode_fall_seen", 32'(n_fall), 32'(1));
    check("fallmode_edge_total", 32'(n_edge), 32'(1));
    check("fallmode_cnt", 32'(edge_cnt[2*CW +: CW]), 32'(1));
    mode[5:4] = MODE_OFF;
    strobe_clr(4'b0100);
    din[2] = 1'b1; ticks(8); din[2] = 1'b0; ticks(8);
    check("offmode_cnt", 32'(edge_cnt[2*CW +: CW]), 32'(0));
    check("offmode_sticky", 32'(sticky[2]), 32'(0));

    // Clear collisions on channel 0
    din[0] = 1'b1; ticks(8);
    din[0] = 1'b0; ticks(SS + FC - 1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("coll_fall", 32'(fall_pulse[0]), 32'(1));
    check("coll_sticky", 32'(sticky[0]), 32'(1));
    check("coll_cnt", 32'(edge_cnt[0 +: CW]), 32'(1));
    strobe_clr(4'b0001);
    check("clr_sticky", 32'(sticky[0]), 32'(0));
    check("clr_cnt", 32'(edge_cnt[0 +: CW]), 32'(0));

    // Saturation on channel 3 (3-bit counter instance)
    strobe_clr(4'b1000);
    for (int k = 0; k < 10; k++) begin din[3] = ~din[3]; ticks(6); end
    check("sat_cnt", 32'(edge_cnt_s[3*CW_S +: CW_S]), 32'(7));
    check("wide_cnt", 32'(edge_cnt[3*CW +: CW]), 32'(10));
    for (int k = 0; k < 2; k++) begin din[3] = ~din[3]; ticks(6); end
    check("sat_hold", 32'(edge_cnt_s[3*CW_S +: CW_S]), 32'(7));

    // Simultaneous edges on all channels
    mode = {CH{MODE_BOTH}};
    din = '0; ticks(8);
    din = '1; ticks(SS + FC);
    check("simul_rise", 32'(rise_pulse), 32'(4'hF));
    check("simul_edge", 32'(edge_pulse), 32'(4'hF));

    // Asynchronous reset part-way through a filter run
    din = '0; ticks(8);
    din[0] = 1'b1; ticks(3);
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    check("arst_cnt1", 32'(edge_cnt[CW +: CW]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    measure(0, 1'b1, lat, width);
    check("post_rst_latency", 32'(lat), 32'(SS + FC));
    check("post_rst_width", 32'(width), 32'(1));

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) mode = 8'($urandom);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, (k / 100) % 2 == 0 ? 3 : 9) == 0) din[c] = ~din[c];
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
      tick();
    end
    clr = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-channel falling-edge detector.
- Each channel does the following:
  - synchronises an asynchronous input;
  - rejects glitches shorter than a programmable number of clocks;
  - reports rising and falling edges as single-cycle pulses, qualified per channel by a mode field;
  - keeps a sticky flag and a saturating edge counter, both cleared by software.
- Sits between raw pins / asynchronous status lines and the control logic or interrupt aggregation.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 3, consecutive clocks a changed level must persist before it is accepted (>=1).
- CNT_WIDTH, 8, width of each per-channel saturating edge counter.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- din  in  CHANNELS  raw asynchronous inputs
- mode  in  2*CHANNELS  per-channel qualifier, channel i at bits [2i+1:2i]
- clr  in  CHANNELS  per-channel clear for sticky and count, one-cycle strobe
- level  out  CHANNELS  filtered, synchronised level
- rise_pulse  out  CHANNELS  one-cycle pulse on an accepted 0->1, not qualified by mode
- fall_pulse  out  CHANNELS  one-cycle pulse on an accepted 1->0, not qualified by mode
- edge_pulse  out  CHANNELS  one-cycle pulse on a mode-qualified edge
- sticky  out  CHANNELS  set on a qualified edge, held until clr
- edge_cnt  out  CHANNELS*CNT_WIDTH  saturating count of qualified edges, channel i at [(i+1)*CNT_WIDTH-1 : i*CNT_WIDTH]

Behaviour:

Reset:
- rst asserts all of the following asynchronously: synchroniser flops, filter counters, level, all pulses, sticky and edge_cnt go to 0.

Mode encoding:
- 00 off
- 01 rising
- 10 falling
- 11 both

Synchroniser:
- din[i] passes through a SYNC_STAGES flop chain; the output is s[i].

Filter (per channel):
- fcnt resets to 0; width is clog2(FILTER_CYCLES)+1.
- If s==level, fcnt <= 0.
- Else if fcnt==FILTER_CYCLES-1: level <= s, fcnt <= 0.
- Else fcnt <= fcnt+1.
- Consequence: a disagreement shorter than FILTER_CYCLES clocks is discarded entirely.

Edge detection:
- On the clock edge where level toggles 0->1, rise_pulse is registered high for exactly one cycle; same rule for 1->0 and fall_pulse.
- rise_pulse and fall_pulse are never high together.
- Latency from a din change (stable before clock edge 1) to a pulse is SYNC_STAGES+FILTER_CYCLES edges; with defaults, high during cycle 5.
- Minimum spacing between pulses on one channel is FILTER_CYCLES cycles.

Qualification:
- edge_pulse = (rise_pulse & mode[0]) | (fall_pulse & mode[1]), registered on the same edge as rise_pulse/fall_pulse.
- mode is sampled on the edge that registers the pulse.
- A mode change never disturbs the synchroniser, filter or level.

Sticky:
- Set on the edge that registers edge_pulse.
- clr alone clears it.
- clr on the same edge as a qualified edge: sticky ends at 1 (set wins).

edge_cnt:
- Increments on each qualified edge.
- Saturates at 2^CNT_WIDTH-1 and holds there; no wrap.
- clr alone loads 0.
- clr together with a qualified edge loads 1.

Reset release:
- level restarts from 0.
- A din held high through reset is reported as one rising edge SYNC_STAGES+FILTER_CYCLES cycles after rst deasserts.
- Reset mid-filter discards the partial count.

Independence:
- Channels are fully independent; simultaneous edges on every channel are all reported in the same cycle.

Decomposition:
- Shared package multi_edge_pkg:
  - mode constants MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH;
  - a 2-bit mode typedef.
- Sub-module edge_chan holds one channel: synchroniser, filter, level, rise/fall/edge pulse, sticky and counter.
- The top instantiates edge_chan CHANNELS times in a generate loop and slices the mode and edge_cnt buses.

Test Plan:
- Basic latency: defaults, mode=11, rst released, din[0] 0->1 held → rise_pulse[0] and edge_pulse[0] high for exactly 1 cycle, 5 clocks after the change; level[0]=1; sticky[0]=1; edge_cnt[0]=1. Then din[0] 1->0 → fall_pulse[0] 5 clocks later; edge_cnt[0]=2.
- Glitch rejection: din[1] pulses high for 2 clocks, then for 3 mid-cycle-asynchronous 3 ns slivers → no pulse, level[1] stays 0, fcnt returns to 0. A 3-clock-stable pulse → one rise then one fall.
- Mode qualification: mode[5:4]=10, toggle din[2] up then down → rise_pulse[2] and fall_pulse[2] both seen; edge_pulse[2] only on the fall; edge_cnt[2]=1. With mode=00 → edge_cnt unchanged, sticky stays 0.
- Clear collisions: clr[0] strobed on the same edge as a qualified fall → sticky[0]=1, edge_cnt[0]=1. clr[0] alone → sticky 0, count 0.
- Saturation: CNT_WIDTH=3, 10 qualified edges on channel 3 → edge_cnt[3] stops at 7 and stays 7.
- Reset mid-operation: din[0]=1 with rst asserted asynchronously mid-filter → all outputs 0 immediately. After deassert, one rise_pulse[0] after 5 clocks; all channels' pulses are simultaneous when their din toggle together.
